retire_queue: RTL and testbench

In-order retirement buffer that feeds the commit stage. Decoded instructions are allocated in program order and written back out of order by tag. The oldest finished entries are presented on NR_COMMIT_PORTS commit ports, and entries are popped on the commit stage's per-port acknowledge. It is the producer side of the `commit_instr`/`commit_ack` handshake and sits between issue/writeback and commit.

---
 rtl/retire_queue.sv | 142 ++++++++++++++
 tb/tb_retire_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_queue.sv
// In-order retirement buffer: allocate in program order, write back by tag,
// present the two oldest finished entries to commit and pop on acknowledge.
package retire_queue_pkg;
  typedef enum logic [2:0] {NONE, ALU, LSU, BRANCH, CSR} fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
  } scoreboard_entry_t;
endpackage

module retire_queue
  import retire_queue_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 2,
  localparam int unsigned IDW            = $clog2(NR_ENTRIES)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  scoreboard_entry_t                       decoded_instr_i,
  input  logic                                    decoded_instr_valid_i,
  output logic                                    decoded_instr_ack_o,
  output logic [IDW-1:0]                          alloc_id_o,
  input  logic [NR_WB_PORTS-1:0]                  wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][IDW-1:0]         wb_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]            wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]            wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]              commit_ack_i,
  output logic                                    full_o,
  output logic                                    empty_o,
  output logic [IDW:0]                            count_o
);

  localparam int unsigned WBW = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  scoreboard_entry_t     mem_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] busy_q, done_q;
  logic [IDW-1:0]        head_q, tail_q;
  logic [IDW:0]          count_q;

  logic                       alloc;
  logic [NR_ENTRIES-1:0]      wb_hit;
  logic [WBW-1:0]             wb_sel [NR_ENTRIES];
  logic [NR_COMMIT_PORTS-1:0] port_valid, pop;
  logic [IDW:0]               pop_cnt;

  assign full_o              = (count_q == (IDW+1)'(NR_ENTRIES));
  assign empty_o             = (count_q == '0);
  assign count_o             = count_q;
  assign alloc_id_o          = tail_q;
  assign alloc               = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign decoded_instr_ack_o = alloc;

  // Ports are scanned high to low so the lowest-indexed hit on a slot wins.
  always_comb begin
    wb_hit = '0;
    for (int unsigned s = 0; s < NR_ENTRIES; s++) begin
      wb_sel[s] = '0;
      for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
        if (wb_valid_i[NR_WB_PORTS-1-k] && wb_id_i[NR_WB_PORTS-1-k] == IDW'(s)
            && busy_q[s] && !done_q[s]) begin
          wb_hit[s] = 1'b1;
          wb_sel[s] = WBW'(NR_WB_PORTS-1-k);
        end
      end
    end
  end

  always_comb begin
    logic [IDW-1:0] idx;
    logic           valid_chain;
    logic           pop_chain;
    valid_chain = 1'b1;
    pop_chain   = 1'b1;
    pop_cnt     = '0;
    idx         = '0;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      idx                     = head_q + IDW'(i);
      valid_chain             = valid_chain & busy_q[idx] & done_q[idx];
      port_valid[i]           = valid_chain;
      commit_instr_o[i]       = mem_q[idx];
      commit_instr_o[i].valid = valid_chain;
      pop_chain               = pop_chain & commit_ack_i[i] & valid_chain;
      pop[i]                  = pop_chain;
      pop_cnt                 = pop_cnt + (IDW+1)'(pop_chain);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned s = 0; s < NR_ENTRIES; s++) begin
        if (wb_hit[s]) done_q[s] <= 1'b1;
      end
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (pop[i]) begin
          busy_q[head_q + IDW'(i)] <= 1'b0;
          done_q[head_q + IDW'(i)] <= 1'b0;
        end
      end
      if (alloc) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= decoded_instr_i.ex.valid || decoded_instr_i.fu == NONE;
      end
      head_q  <= head_q + pop_cnt[IDW-1:0];
      tail_q  <= tail_q + IDW'(alloc);
      count_q <= count_q + (IDW+1)'(alloc) - pop_cnt;
    end
  end

  // Payload is not reset; busy/done alone decide whether a slot is live.
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NR_ENTRIES; s++) begin
      if (wb_hit[s]) begin
        mem_q[s].result <= wb_result_i[wb_sel[s]];
        if (wb_ex_i[wb_sel[s]].valid) mem_q[s].ex <= wb_ex_i[wb_sel[s]];
      end
    end
    if (alloc) mem_q[tail_q] <= decoded_instr_i;
  end

endmodule

// File: tb/tb_retire_queue.sv
// Randomized and directed bench for retire_queue against a program-order queue model.
module tb_retire_queue;
  import retire_queue_pkg::*;

  localparam int unsigned N   = 8;
  localparam int unsigned NC  = 2;
  localparam int unsigned NW  = 2;
  localparam int unsigned IDW = 3;

  logic                        clk = 1'b0;
  logic                        rst_n, flush;
  scoreboard_entry_t           instr;
  logic                        instr_v, instr_ack;
  logic [IDW-1:0]              alloc_id;
  logic [NW-1:0]               wb_v;
  logic [NW-1:0][IDW-1:0]      wb_id;
  logic [NW-1:0][63:0]         wb_res;
  exception_t [NW-1:0]         wb_ex;
  scoreboard_entry_t [NC-1:0]  commit;
  logic [NC-1:0]               ack;
  logic                        full, empty;
  logic [IDW:0]                count;

  always #5 clk = ~clk;

  retire_queue #(.NR_ENTRIES(N), .NR_COMMIT_PORTS(NC), .NR_WB_PORTS(NW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .decoded_instr_i(instr), .decoded_instr_valid_i(instr_v),
    .decoded_instr_ack_o(instr_ack), .alloc_id_o(alloc_id),
    .wb_valid_i(wb_v), .wb_id_i(wb_id), .wb_result_i(wb_res), .wb_ex_i(wb_ex),
    .commit_instr_o(commit), .commit_ack_i(ack),
    .full_o(full), .empty_o(empty), .count_o(count)
  );

  typedef struct {
    int                tag;
    bit                done;
    scoreboard_entry_t e;
  } ent_t;

  ent_t q[$];
  int   tail_m;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input fu_t fu, input logic [63:0] pc,
                                           input logic exv, input logic [63:0] cause);
    scoreboard_entry_t e;
    e          = '0;
    e.pc       = pc;
    e.fu       = fu;
    e.op       = 8'h11;
    e.rd       = pc[4:0];
    e.valid    = 1'b1;
    e.ex.valid = exv;
    e.ex.cause = cause;
    return e;
  endfunction

  task automatic idle();
    flush   = 1'b0;
    instr_v = 1'b0;
    instr   = '0;
    wb_v    = '0;
    wb_id   = '0;
    wb_res  = '0;
    wb_ex   = '0;
    ack     = '0;
  endtask

  function automatic bit port_ok(input int p);
    if (p == 0) return q.size() > 0 && q[0].done;
    return port_ok(p - 1) && q.size() > p && q[p].done;
  endfunction

  task automatic compare_all();
    int sz;
    sz = q.size();
    check("count", 64'(count), 64'(sz));
    check("full", 64'(full), 64'(sz == N));
    check("empty", 64'(empty), 64'(sz == 0));
    check("alloc_id", 64'(alloc_id), 64'(tail_m));
    check("instr_ack", 64'(instr_ack), 64'(instr_v && sz != N && !flush));
    for (int p = 0; p < NC; p++) begin
      check($sformatf("p%0d_valid", p), 64'(commit[p].valid), 64'(port_ok(p)));
      if (port_ok(p)) begin
        check($sformatf("p%0d_pc", p), commit[p].pc, q[p].e.pc);
        check($sformatf("p%0d_fu", p), 64'(commit[p].fu), 64'(q[p].e.fu));
        check($sformatf("p%0d_result", p), commit[p].result, q[p].e.result);
        check($sformatf("p%0d_exv", p), 64'(commit[p].ex.valid), 64'(q[p].e.ex.valid));
        check($sformatf("p%0d_cause", p), commit[p].ex.cause, q[p].e.ex.cause);
      end
    end
  endtask

  task automatic update_model();
    int  sz;
    bit  v0, v1, pop0, pop1;
    if (!rst_n || flush) begin
      q.delete();
      tail_m = 0;
      return;
    end
    sz   = q.size();
    v0   = port_ok(0);
    v1   = port_ok(1);
    pop0 = ack[0] && v0;
    pop1 = pop0 && ack[1] && v1;
    // Port 0 is applied first; a second hit then finds the entry already done.
    for (int p = 0; p < NW; p++) begin
      if (wb_v[p]) begin
        foreach (q[k]) begin
          if (q[k].tag == int'(wb_id[p]) && !q[k].done) begin
            q[k].done     = 1'b1;
            q[k].e.result = wb_res[p];
            if (wb_ex[p].valid) q[k].e.ex = wb_ex[p];
          end
        end
      end
    end
    if (pop0) void'(q.pop_front());
    if (pop1) void'(q.pop_front());
    if (instr_v && sz != N) begin
      ent_t n;
      n.tag  = tail_m;
      n.done = instr.ex.valid || instr.fu == NONE;
      n.e    = instr;
      q.push_back(n);
      tail_m = (tail_m + 1) % N;
    end
  endtask

  task automatic step();
    #1;
    compare_all();
    update_model();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int r;
    idle();
    rst_n = 1'b0;
    q.delete();
    tail_m = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Fill with unfinished ALU ops, 9th request refused
    for (int i = 0; i < 9; i++) begin
      instr_v = 1'b1;
      instr   = mk(ALU, 64'h1000 + 64'(i), 1'b0, 64'h0);
      step();
    end
    #1;
    check("fill_full", 64'(full), 64'h1);
    check("fill_9th_ack", 64'(instr_ack), 64'h0);
    idle();
    wb_v   = 2'b11;
    wb_id  = {3'd1, 3'd0};
    wb_res = {64'hB1, 64'hB0};
    step();
    idle();
    ack = 2'b11;
    #1;
    check("drain_v0", 64'(commit[0].valid), 64'h1);
    check("drain_v1", 64'(commit[1].valid), 64'h1);
    step();
    idle();
    #1;
    check("drain_count", 64'(count), 64'd6);
    do_flush();

    // Out-of-order writeback
    for (int i = 0; i < 3; i++) begin
      instr_v = 1'b1;
      instr   = mk(ALU, 64'h2000 + 64'(i), 1'b0, 64'h0);
      step();
    end
    idle();
    wb_v = 2'b01; wb_id[0] = 3'd2; wb_res[0] = 64'h22;
    step();
    wb_id[0] = 3'd1; wb_res[0] = 64'h11;
    wb_v[1] = 1'b1; wb_id[1] = 3'd1; wb_res[1] = 64'h99;
    wb_ex[1].valid = 1'b1; wb_ex[1].cause = 64'd7;
    step();
    idle();
    #1;
    check("ooo_p0_invalid", 64'(commit[0].valid), 64'h0);
    wb_v = 2'b01; wb_id[0] = 3'd0; wb_res[0] = 64'hDEAD;
    step();
    idle();
    #1;
    check("ooo_p0_result", commit[0].result, 64'hDEAD);
    check("ooo_p1_valid", 64'(commit[1].valid), 64'h1);
    check("ooo_p1_lowport", commit[1].result, 64'h11);
    step();
    do_flush();

    // Exception at decode retires without writeback; lone ack[1] ignored
    instr_v = 1'b1;
    instr   = mk(ALU, 64'h3000, 1'b1, 64'd2);
    step();
    idle();
    #1;
    check("exc_p0_valid", 64'(commit[0].valid), 64'h1);
    check("exc_cause", commit[0].ex.cause, 64'd2);
    ack = 2'b10;
    step();
    idle();
    #1;
    check("exc_ack1_count", 64'(count), 64'd1);
    do_flush();

    // Wrap-around at one alloc/writeback/retire per cycle
    for (int i = 0; i < 20; i++) begin
      idle();
      instr_v = 1'b1;
      instr   = mk(ALU, 64'h4000 + 64'(i), 1'b0, 64'h0);
      if (i > 0) begin
        wb_v[0]   = 1'b1;
        wb_id[0]  = IDW'((i - 1) % N);
        wb_res[0] = 64'h4400 + 64'(i);
      end
      ack = 2'b01;
      #1;
      check($sformatf("wrap_id%0d", i), 64'(alloc_id), 64'(i % N));
      step();
    end
    do_flush();
    for (int i = 0; i < 8; i++) begin
      idle();
      instr_v = (i < 7);
      instr   = mk(NONE, 64'h5000 + 64'(i), 1'b0, 64'h0);
      ack     = 2'b01;
      step();
    end
    idle();
    instr_v = 1'b1; instr = mk(ALU, 64'h70, 1'b0, 64'h0);
    step();
    instr = mk(ALU, 64'h80, 1'b0, 64'h0);
    step();
    idle();
    wb_v = 2'b11; wb_id = {3'd0, 3'd7}; wb_res = {64'hA0, 64'hA7};
    step();
    idle();
    #1;
    check("wrap_p0_pc", commit[0].pc, 64'h70);
    check("wrap_p1_pc", commit[1].pc, 64'h80);
    check("wrap_p1_valid", 64'(commit[1].valid), 64'h1);
    step();
    do_flush();

    // Flush racing alloc, writeback and pop
    for (int i = 0; i < 5; i++) begin
      idle();
      instr_v = 1'b1;
      instr   = mk((i < 2) ? NONE : ALU, 64'h6000 + 64'(i), 1'b0, 64'h0);
      step();
    end
    idle();
    flush = 1'b1; instr_v = 1'b1; instr = mk(ALU, 64'h6100, 1'b0, 64'h0);
    wb_v = 2'b01; wb_id[0] = 3'd3; wb_res[0] = 64'h33; ack = 2'b11;
    step();
    idle();
    #1;
    check("flush_count", 64'(count), 64'h0);
    check("flush_empty", 64'(empty), 64'h1);
    check("flush_alloc_id", 64'(alloc_id), 64'h0);
    instr_v = 1'b1; instr = mk(ALU, 64'h6200, 1'b0, 64'h0);
    step();
    idle();
    wb_v = 2'b01; wb_id[0] = 3'd3; wb_res[0] = 64'h3333;
    step();
    idle();
    step();
    do_flush();

    // Full with simultaneous pop and alloc
    for (int i = 0; i < 8; i++) begin
      idle();
      instr_v = 1'b1;
      instr   = mk(NONE, 64'h7000 + 64'(i), 1'b0, 64'h0);
      step();
    end
    idle();
    instr_v = 1'b1; instr = mk(ALU, 64'h7100, 1'b0, 64'h0); ack = 2'b01;
    #1;
    check("fullpop_ack", 64'(instr_ack), 64'h0);
    step();
    ack = 2'b00;
    #1;
    check("fullpop_count", 64'(count), 64'd7);
    check("fullpop_ack2", 64'(instr_ack), 64'h1);
    check("fullpop_id", 64'(alloc_id), 64'h0);
    step();
    do_flush();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      r       = $urandom_range(0, 99);
      instr_v = (r < 70);
      instr   = mk(($urandom_range(0, 3) == 0) ? NONE : ALU, 64'({$urandom, $urandom}),
                   ($urandom_range(0, 9) == 0), 64'($urandom_range(0, 15)));
      for (int p = 0; p < NW; p++) begin
        wb_v[p] = ($urandom_range(0, 1) == 1);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          wb_id[p] = IDW'(q[$urandom_range(0, q.size() - 1)].tag);
        else
          wb_id[p] = IDW'($urandom_range(0, N - 1));
        wb_res[p]      = {$urandom, $urandom};
        wb_ex[p].valid = ($urandom_range(0, 7) == 0);
        wb_ex[p].cause = 64'($urandom_range(16, 31));
        wb_ex[p].tval  = 64'($urandom);
      end
      ack   = NC'($urandom_range(0, 3));
      flush = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
